alu_pipe: RTL and testbench

- Next-generation ALU: width-parametrised, registered outputs, valid/ready handshake on both sides, extended flags.
- Adds shifts, XOR and an iterative shift-add multiply; the multiply holds the unit busy for WIDTH cycles.
- Sits between operand fetch and writeback in the processor datapath, replacing the combinational 48-bit ALU.
- One operation in flight at a time.

---
 rtl/alu_pipe.sv | 190 +++++++++++++++++++
 tb/tb_alu_pipe.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Width-parametrised registered ALU with valid/ready on both sides.
// Single-cycle logic/arith/shift ops; MUL iterates shift-add for WIDTH cycles.
module alu_pipe #(
   parameter int WIDTH = 48,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             overflow,
   output logic             negative,
   output logic             illegal,
   output logic [1:0]       dbg_state
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_XOR = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_SLL = 4'b1000;
   localparam logic [3:0] OP_SRL = 4'b1001;
   localparam logic [3:0] OP_SRA = 4'b1010;
   localparam logic [3:0] OP_MUL = 4'b1011;
   localparam logic [3:0] OP_NOR = 4'b1100;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_e;

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; valid never waits on ready, and output data is stable while
   // out_valid is high and out_ready is low.
   state_e           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;
   logic             neg_q, neg_d, ill_q, ill_d;
   logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
   logic [SHW-1:0]   cnt_q, cnt_d;

   logic [WIDTH:0]   add_ext, sub_ext;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] alu_res, mul_sum;
   logic             alu_c, alu_v, alu_ill, accept;

   assign add_ext = {1'b0, a} + {1'b0, b};
   assign sub_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
   assign shamt   = b[SHW-1:0];
   assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

   // Shifts by amounts >= WIDTH naturally produce 0 or full sign fill.
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_ill = 1'b0;
      case (control)
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_XOR: alu_res = a ^ b;
         OP_NOR: alu_res = ~(a | b);
         OP_ADD: begin
            alu_res = add_ext[WIDTH-1:0];
            alu_c   = add_ext[WIDTH];
            alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = sub_ext[WIDTH-1:0];
            alu_c   = sub_ext[WIDTH];
            alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLL: alu_res = a << shamt;
         OP_SRL: alu_res = a >> shamt;
         OP_SRA: alu_res = $signed(a) >>> shamt;
         OP_MUL: alu_res = '0;
         default: alu_ill = 1'b1;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      case (state_q)
         S_IDLE:  in_ready = 1'b1;
         S_MUL:   in_ready = 1'b0;
         S_HOLD:  in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
      in_ready = in_ready & rst_n;
   end

   assign accept = in_valid & in_ready;

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
      neg_d    = neg_q;
      ill_d    = ill_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_MUL: begin
            acc_d    = mul_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + SHW'(1);
            if (cnt_q == SHW'(WIDTH - 1)) begin
               result_d = mul_sum;
               zero_d   = (mul_sum == '0);
               neg_d    = mul_sum[WIDTH-1];
               carry_d  = 1'b0;
               ovf_d    = 1'b0;
               ill_d    = 1'b0;
               state_d  = S_HOLD;
            end
         end
         S_HOLD: if (out_ready && !in_valid) state_d = S_IDLE;
         default: state_d = state_q;
      endcase
      // Accept is only possible in IDLE, or in HOLD while the result drains.
      if (accept) begin
         if (control == OP_MUL) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
         end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            neg_d    = alu_res[WIDTH-1];
            carry_d  = alu_c;
            ovf_d    = alu_v;
            ill_d    = alu_ill;
            state_d  = S_HOLD;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         neg_q    <= 1'b0;
         ill_q    <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
         neg_q    <= neg_d;
         ill_q    <= ill_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

   assign out_valid = (state_q == S_HOLD);
   assign result    = result_q;
   assign zero      = zero_q;
   assign carry     = carry_q;
   assign overflow  = ovf_q;
   assign negative  = neg_q;
   assign illegal   = ill_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed cases with literal expectations plus random
// traffic checked every cycle against an arithmetic reference model.
module tb_alu_pipe;
  localparam int W   = 48;
  localparam int SHW = $clog2(W);
  localparam int EW  = W + 3;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic [3:0]   control;
  logic         zero, carry, overflow, negative, illegal;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit rand_ready = 0;

  // Each entry: {illegal, overflow, carry, result}; due_q is the first cycle
  // count at which out_valid must be high for that entry.
  logic [EW-1:0] exp_q[$];
  int            due_q[$];

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .control(control), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .carry(carry),
    .overflow(overflow), .negative(negative), .illegal(illegal),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [EW-1:0] model(input logic [3:0] op, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    longint unsigned ux, uy, mask, full, r;
    longint sx, sy, s, smax, smin;
    int amt;
    logic c, v, ill;
    c = 0; v = 0; ill = 0; r = 0;
    ux = x; uy = y; sx = $signed(x); sy = $signed(y);
    mask = (64'd1 << W) - 1;
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -smax - 1;
    amt  = int'(uy % (64'd1 << SHW));
    case (op)
      4'd0:  r = ux & uy;
      4'd1:  r = ux | uy;
      4'd3:  r = ux ^ uy;
      4'd12: r = ~(ux | uy) & mask;
      4'd2: begin
        full = ux + uy; r = full & mask; c = (full > mask);
        s = sx + sy; v = (s > smax) || (s < smin);
      end
      4'd6: begin
        r = (ux - uy) & mask; c = (ux >= uy);
        s = sx - sy; v = (s > smax) || (s < smin);
      end
      4'd7:  r = (sx < sy) ? 1 : 0;
      4'd8:  r = (amt >= W) ? 0 : (ux << amt) & mask;
      4'd9:  r = (amt >= W) ? 0 : (ux >> amt);
      4'd10: r = (amt >= W) ? ((sx < 0) ? mask : 0) : (longint'(sx >>> amt) & mask);
      4'd11: r = (ux * uy) & mask;
      default: ill = 1;
    endcase
    return {ill, v, c, r[W-1:0]};
  endfunction

  // scoreboard / compare process
  logic          exp_v, exp_rdy;
  logic [EW-1:0] e;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      due_q.delete();
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_flags", {zero, carry, overflow, negative, illegal}, 0);
    end else begin
      exp_v   = (exp_q.size() > 0) && (cyc >= due_q[0]);
      exp_rdy = (exp_q.size() == 0) || (exp_v && out_ready);
      check("out_valid", out_valid, exp_v);
      check("in_ready", in_ready, exp_rdy);
      if (exp_v) begin
        e = exp_q[0];
        check("result", result, e[W-1:0]);
        check("zero", zero, e[W-1:0] == '0);
        check("negative", negative, e[W-1]);
        check("carry", carry, e[W]);
        check("overflow", overflow, e[W+1]);
        check("illegal", illegal, e[W+2]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
      end
      if (in_valid && exp_rdy) begin
        exp_q.push_back(model(control, a, b));
        due_q.push_back(cyc + 1 + ((control == 4'b1011) ? W : 0));
      end
    end
  end

  function automatic logic [W-1:0] rand_word();
    logic [63:0] t;
    case ($urandom_range(0, 9))
      0: t = 64'(ONES);
      1: t = 0;
      2: t = 64'(ONES >> 1);
      3: t = 64'(~(ONES >> 1));
      default: t = {$urandom, $urandom};
    endcase
    return t[W-1:0];
  endfunction

  // driver tasks
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [3:0] tc,
                      output logic ov, output logic [W-1:0] rs);
    bit acc = 0;
    a = ta; b = tb_; control = tc; in_valid = 1;
    ov = 0; rs = '0;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      ov  = out_valid;
      rs  = result;
      @(posedge clk);
      #2;
    end
    check("send_accept", acc, 1);
    in_valid = 0;
    a = rand_word(); b = rand_word(); control = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_result(output int lat, output int nbusy, output logic [W-1:0] rs,
                             output logic [4:0] fl);
    bit got = 0;
    lat = 0; nbusy = 0; rs = '0; fl = '0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1;
        rs  = result;
        fl  = {zero, carry, overflow, negative, illegal};
      end else begin
        lat++;
        if (!in_ready) nbusy++;
      end
    end
    check("result_timeout", got, 1);
    @(posedge clk);
    #2;
  endtask

  task automatic op_expect(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                           input logic [3:0] tc, input logic [W-1:0] er, input logic [4:0] ef);
    logic ov; logic [W-1:0] rs, r; logic [4:0] fl; int lat, nb;
    send(ta, tb_, tc, ov, rs);
    wait_result(lat, nb, r, fl);
    check({name, "_lat"}, lat, 0);
    check({name, "_res"}, r, er);
    check({name, "_flags"}, fl, ef);
  endtask

  logic [W-1:0] sa[4], sb[4];

  initial begin
    logic ov; logic [W-1:0] rs, r; logic [4:0] fl; int lat, nb, cnt;
    rst_n = 0; in_valid = 0; out_ready = 1; a = '0; b = '0; control = '0;

    // model pins
    check("pin_add", model(4'b0010, ONES >> 1, 1), {3'b010, ~(ONES >> 1)});
    check("pin_sub", model(4'b0110, 3, 5), {3'b000, ONES - 1});
    check("pin_mul", model(4'b1011, ONES, ONES), {3'b000, 48'd1});
    check("pin_sra", model(4'b1010, ~(ONES >> 1), 47), {3'b000, ONES});

    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1);
    @(posedge clk); #2;

    // flags order: {zero, carry, overflow, negative, illegal}
    op_expect("and_ones", ONES, ONES, 4'b0000, ONES, 5'b00010);
    op_expect("and_zero", '0, ONES, 4'b0000, '0, 5'b10000);
    op_expect("add_ovf", ONES >> 1, 1, 4'b0010, ~(ONES >> 1), 5'b00110);
    op_expect("sub_eq", 5, 5, 4'b0110, '0, 5'b11000);
    op_expect("sub_neg", 3, 5, 4'b0110, ONES - 1, 5'b00010);
    op_expect("sra_47", ~(ONES >> 1), 47, 4'b1010, ONES, 5'b00010);
    op_expect("sll_48", ONES, 48, 4'b1000, '0, 5'b10000);
    op_expect("slt_m1", ONES, 1, 4'b0111, 1, 5'b00000);
    op_expect("illegal", ONES, ONES, 4'b1111, '0, 5'b10001);

    // MUL latency and results
    send(48'h123456, 48'h1000, 4'b1011, ov, rs);
    wait_result(lat, nb, r, fl);
    check("mul_lat", lat, W);
    check("mul_busy", nb, W);
    check("mul_res", r, 48'h123456000);
    send(ONES, ONES, 4'b1011, ov, rs);
    wait_result(lat, nb, r, fl);
    check("mul_ones_res", r, 1);
    check("mul_ones_flags", fl, 5'b00000);

    // backpressure
    out_ready = 0;
    send(10, 20, 4'b0010, ov, rs);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_result", result, 30);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #2 out_ready = 1;
    @(posedge clk); #2;

    // back-to-back stream
    for (int k = 0; k < 4; k++) begin
      sa[k] = rand_word() | 48'h100;
      sb[k] = 48'h1111 * (k + 1);
    end
    for (int k = 0; k < 4; k++) begin
      send(sa[k], sb[k], 4'b0010, ov, rs);
      if (k > 0) begin
        check("stream_valid", ov, 1);
        check("stream_sum", rs, W'(sa[k-1] + sb[k-1]));
      end
    end
    wait_result(lat, nb, r, fl);
    check("stream_last_lat", lat, 0);
    check("stream_last_sum", r, W'(sa[3] + sb[3]));
    op_expect("pre_rst_nonzero", 48'h55, 48'h0F, 4'b0011, 48'h5A, 5'b00000);

    // reset in the middle of a MUL
    send(rand_word() | 1, 48'h3, 4'b1011, ov, rs);
    repeat (19) @(posedge clk);
    #3 rst_n = 0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_result", result, 0);
    @(posedge clk); @(posedge clk); #2 rst_n = 1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("midrst_no_stale", cnt, 0);
    @(posedge clk); #2;

    // random traffic
    rand_ready = 1;
    for (int n = 0; n < 400; n++) begin
      logic [3:0] c;
      logic [W-1:0] x, y;
      c = 4'($urandom_range(0, 15));
      if (c == 4'b1011 && $urandom_range(0, 3) != 0) c = 4'b0010;
      x = rand_word();
      y = rand_word();
      if ((c >= 4'b1000) && (c <= 4'b1010) && $urandom_range(0, 1) == 1)
        y = W'($urandom_range(0, 63));
      send(x, y, c, ov, rs);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #2;
      end
    end
    rand_ready = 0;
    out_ready  = 1;
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
